// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
// Register file (NREGS x XLEN, x0 hardwired to zero) plus the decode-to-execute
// pipeline register. It accepts decoded rs1/rs2/rd/alu_control fields, reads both
// source operands combinationally, and presents them to the ALU one cycle later
// through a valid/ready handshake. The write-back port is never stalled.
//
// Optional feature macro: OPFETCH_WB_FORWARD_EN
//   defined   : a write-back in the same cycle as an accept is forwarded into the
//               captured operand, and a write-back matching a held operand's
//               index refreshes that held operand.
//   undefined : captures see the pre-write value and held operands are frozen.
module operand_fetch_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic [4:0]      alu_control,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_alu_control
);

    // Architectural state
    logic [XLEN-1:0] regs_r [NREGS];

    // Pipeline register and the source indices it was captured from
    logic            out_valid_r;
    logic [XLEN-1:0] out_rs1_data_r;
    logic [XLEN-1:0] out_rs2_data_r;
    logic [4:0]      out_rd_r;
    logic [4:0]      out_alu_control_r;
    logic [4:0]      rs1_idx_r;
    logic [4:0]      rs2_idx_r;

    // Handshake and datapath helpers
    logic            in_ready_s;
    logic            accept_s;
    logic            drain_s;
    logic            hold_s;
    logic            wb_write_s;
    logic [XLEN-1:0] rs1_rdata_s;
    logic [XLEN-1:0] rs2_rdata_s;
    logic [XLEN-1:0] rs1_cap_s;
    logic [XLEN-1:0] rs2_cap_s;

    // Handshake decode: the stage is free when empty or when the ALU takes the held entry
    always_comb begin
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        drain_s    = 1'b0;
        hold_s     = 1'b0;
        wb_write_s = 1'b0;
        in_ready_s = (!out_valid_r) || out_ready;
        accept_s   = in_valid && in_ready_s;
        drain_s    = out_valid_r && out_ready && !accept_s;
        hold_s     = out_valid_r && !out_ready;
        // A write to x0 (or to an index beyond the file) is dropped
        if ((wb_rd != 5'd0) && (int'(wb_rd) < NREGS)) begin
            wb_write_s = wb_en;
        end else begin
            wb_write_s = 1'b0;
        end
    end

    // Combinational register reads; x0 always returns zero
    always_comb begin
        rs1_rdata_s = {XLEN{1'b0}};
        rs2_rdata_s = {XLEN{1'b0}};
        if ((rs1 != 5'd0) && (int'(rs1) < NREGS)) begin
            rs1_rdata_s = regs_r[rs1];
        end else begin
            rs1_rdata_s = {XLEN{1'b0}};
        end
        if ((rs2 != 5'd0) && (int'(rs2) < NREGS)) begin
            rs2_rdata_s = regs_r[rs2];
        end else begin
            rs2_rdata_s = {XLEN{1'b0}};
        end
    end

    // Operand values captured on accept, optionally bypassing a same-cycle write-back
    always_comb begin
        rs1_cap_s = rs1_rdata_s;
        rs2_cap_s = rs2_rdata_s;
`ifdef OPFETCH_WB_FORWARD_EN
        if (wb_write_s && (wb_rd == rs1)) begin
            rs1_cap_s = wb_data;
        end else begin
            rs1_cap_s = rs1_rdata_s;
        end
        if (wb_write_s && (wb_rd == rs2)) begin
            rs2_cap_s = wb_data;
        end else begin
            rs2_cap_s = rs2_rdata_s;
        end
`else
        // Read-before-write: the operand sees the value prior to this edge's write
        rs1_cap_s = rs1_rdata_s;
        rs2_cap_s = rs2_rdata_s;
`endif
    end

    // Register file write port, independent of the handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_write_s) begin
            regs_r[wb_rd] <= wb_data;
        end
    end

    // Pipeline register: accept (with optional replace), drain, or hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r       <= 1'b0;
            out_rs1_data_r    <= {XLEN{1'b0}};
            out_rs2_data_r    <= {XLEN{1'b0}};
            out_rd_r          <= 5'd0;
            out_alu_control_r <= 5'd0;
            rs1_idx_r         <= 5'd0;
            rs2_idx_r         <= 5'd0;
        end else if (accept_s) begin
            out_valid_r       <= 1'b1;
            out_rs1_data_r    <= rs1_cap_s;
            out_rs2_data_r    <= rs2_cap_s;
            out_rd_r          <= rd;
            out_alu_control_r <= alu_control;
            rs1_idx_r         <= rs1;
            rs2_idx_r         <= rs2;
        end else if (drain_s) begin
            out_valid_r <= 1'b0;
        end else if (hold_s) begin
`ifdef OPFETCH_WB_FORWARD_EN
            // Keep a stalled operand coherent with a write to its source register;
            // wb_write_s already excludes x0, so a stored zero index never matches
            if (wb_write_s && (wb_rd == rs1_idx_r)) begin
                out_rs1_data_r <= wb_data;
            end
            if (wb_write_s && (wb_rd == rs2_idx_r)) begin
                out_rs2_data_r <= wb_data;
            end
`else
            out_rs1_data_r <= out_rs1_data_r;
            out_rs2_data_r <= out_rs2_data_r;
`endif
        end
    end

    assign in_ready        = in_ready_s;
    assign out_valid       = out_valid_r;
    assign out_rs1_data    = out_rs1_data_r;
    assign out_rs2_data    = out_rs2_data_r;
    assign out_rd          = out_rd_r;
    assign out_alu_control = out_alu_control_r;

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Holds the 32-entry integer register file and the decode-to-execute pipeline register. It sits directly downstream of the R-type decoder. It accepts the decoded rs1/rs2/rd/alu_control fields, reads both source operands, and presents them one cycle later to the ALU through a valid/ready handshake. It also takes the write-back port from the end of the pipeline.

## Interface
Parameters:
- XLEN, 32, data width of registers and operands
- NREGS, 32, number of architectural registers; index width is 5 bits, fixed

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept; = !out_valid || out_ready (combinational)
- rs1  in  5  source register 1 index
- rs2  in  5  source register 2 index
- rd  in  5  destination register index, passed through
- alu_control  in  5  ALU operation code from decoder, passed through unchanged
- wb_en  in  1  write-back enable
- wb_rd  in  5  write-back register index
- wb_data  in  XLEN  write-back value
- out_valid  out  1  registered operands valid
- out_ready  in  1  ALU accepts current output
- out_rs1_data  out  XLEN  operand 1
- out_rs2_data  out  XLEN  operand 2
- out_rd  out  5  registered rd
- out_alu_control  out  5  registered alu_control

## Operation
- Register file: NREGS x XLEN flops. Reads are combinational. x0 always reads 0.
- Writes: when wb_en=1 and wb_rd!=0, reg[wb_rd] is written at the clock edge. A write with wb_rd=0 is discarded.
- Accept: when in_valid && in_ready, the following are loaded:
  - out_rs1_data/out_rs2_data with read values of rs1/rs2
  - out_rd and out_alu_control
  - internal copies of rs1/rs2 indices
  - out_valid is set to 1.
- Drain: when out_valid && out_ready && !(in_valid && in_ready), out_valid is cleared.
- Hold: when out_valid && !out_ready, the following keep their values, except as described under Configuration:
  - out_rd, out_alu_control and the stored indices hold.
  - in_ready=0.
- Accept and drain in the same cycle: the new instruction replaces the old one, and out_valid stays 1. This gives full throughput.
- Input fields are ignored when in_valid=0 or in_ready=0.
- Write-back is independent of the handshake and is never stalled.

## Timing
- Reset values:
  - out_valid=0
  - all out_* data/index fields=0
  - all register file entries=0
  - in_ready=1 while reset is deasserted and out_valid=0
- Latency: accept at edge N gives out_valid=1 with operands after edge N.
- Throughput: 1 instruction/cycle while out_ready=1.
- Read-after-write is visible at the next edge. A write at edge N is returned by a read captured at edge N+1 or later.
- Same-cycle read and write of the same register follows Configuration.
- Reset asserted mid-operation: out_valid drops to 0 immediately, and the in-flight instruction and all register contents are lost.

## Configuration
- OPFETCH_WB_FORWARD_EN defined:
  - An accept in the same cycle as wb_en=1 with wb_rd==rs1 (or rs2) and wb_rd!=0 captures wb_data for that operand.
  - While holding, a write-back whose wb_rd matches a stored nonzero index updates the corresponding out_*_data at that edge.
- OPFETCH_WB_FORWARD_EN undefined:
  - A same-cycle capture gets the pre-write value (read-before-write).
  - Held operands never change while holding. Hazards are then the scheduler's responsibility.

## Test plan
- Reset, then write x5=0x0000_1234 and x6=0x0000_0010. Next cycle accept rs1=5, rs2=6, rd=7, alu_control=ADD. Required: one cycle later out_valid=1, operands 0x1234/0x10, out_rd=7.
- Write wb_rd=0, wb_data=0xDEAD_BEEF, then accept rs1=0, rs2=0. Required: both operands=0.
- out_ready=0 for 3 cycles with a valid output. Required: in_ready=0 and outputs stable; a new in_valid is not accepted. Raise out_ready together with in_valid: back-to-back transfer with no bubble.
- Same cycle: accept rs1=3 and write x3=0xAAAA_5555 over the old value 1. Required: operand=0xAAAA_5555 with the macro, 1 without it.
- Hold on rs2=9 while writing x9=0x77. Required: out_rs2_data becomes 0x77 with the macro; unchanged without it.
- Assert reset while out_valid=1 mid-stall. Required: out_valid=0 asynchronously; all registers read 0 after release.
